// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the uart_rx receiver.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data, valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx,
    input  data, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB-first, even parity, 1 stop; 1-cycle valid pulse.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit, decision at mid+1.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int DIVIDER   = CLK_FREQ / BAUD;
  localparam int HALF      = DIVIDER / 2;
  localparam int CNT_WIDTH = $clog2(DIVIDER);

  // Bit decisions in START happen at mid-start; every later decision sits one
  // full bit after the previous, which the free-running cnt wrap provides.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_WIDTH-1:0] START_PT = CNT_WIDTH'(HALF + 1);
`else
  localparam logic [CNT_WIDTH-1:0] START_PT = CNT_WIDTH'(HALF);
`endif
  localparam logic [CNT_WIDTH-1:0] BIT_PT   = CNT_WIDTH'(DIVIDER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [7:0]           data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;

  logic sync1_q, sync2_q, rx_prev_q;
  logic rx_s, bit_val, fall;

  assign rx_s = sync2_q;
  assign fall = rx_prev_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_prev2_q <= 1'b1;
    else          rx_prev2_q <= rx_prev_q;
  end

  assign bit_val = (rx_prev2_q & rx_prev_q) | (rx_prev2_q & rx_s) | (rx_prev_q & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // NOTE: synchronizer and edge history reset to 1 (idle line) so that
  // releasing reset can never look like a falling start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= bus.rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= rx_s;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // computation lives in the always_comb below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
    end
  end

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == BIT_PT) ? '0 : cnt_q + CNT_WIDTH'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A line held low after a framing error shows no edge, so IDLE
        // stays put until rx_s has gone high again.
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == START_PT) begin
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_PT) begin
          shreg_d = {bit_val, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_PT) begin
          par_d   = bit_val;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_PT) begin
          data_d  = shreg_q;
          perr_d  = (^shreg_q) ^ par_q;
          ferr_d  = ~bit_val;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// against a frame-level reference model (expected byte/error queue).
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic prev_valid = 1'b0;
  logic wide_seen  = 1'b0;
  logic busy_seen  = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) obs_q.push_back('{bus.data, bus.parity_err, bus.frame_err, cyc});
    if (bus.valid === 1'b1 && prev_valid) wide_seen = 1'b1;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
    prev_valid = bus.valid;
  end

  // Drives the first nbits bits of a frame; a full frame adds its expected result.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits = 11);
    logic [10:0] bits;
    int          stop_cyc;
    bits = {stp, par, d, 1'b0};
    stop_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      bus.rx = bits[i];
      if (i == 10) stop_cyc = cyc;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        if (i == 5 && c == HALF) check("busy_mid", bus.busy, 1);
      end
    end
    if (nbits == 11) begin
      exp_q.push_back('{d, logic'((^d) != par), ~stp, stop_cyc});
      last_data = d;
    end
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * DIV) @(negedge clk);
  endtask

  // Compares every observed frame with the model, then empties both queues.
  task automatic drain(input string tag);
    int n;
    int lat;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, obs_q[i].d, exp_q[i].d);
      check({tag, "_perr"}, obs_q[i].pe, exp_q[i].pe);
      check({tag, "_ferr"}, obs_q[i].fe, exp_q[i].fe);
      lat = obs_q[i].cyc - exp_q[i].cyc;
      check({tag, "_lat_in_stop"}, (lat >= HALF && lat <= DIV), 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", bus.data, 8'h00);
    check("rst_valid", bus.valid, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    idle_bits(2);

    // Clean frame, busy drops once the frame is done.
    check("busy_idle", bus.busy, 0);
    send_good(8'hA5);
    idle_bits(2);
    check("busy_after", bus.busy, 0);
    drain("a5");

    // Wrong parity bit.
    send_frame(8'h01, 1'b0, 1'b1);
    idle_bits(2);
    drain("perr");

    // Framing error followed by a long break: exactly one report.
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (40 * DIV) @(negedge clk);
    idle_bits(3);
    drain("break");
    send_good(8'h5A);
    idle_bits(2);
    drain("rearm");

    // Short start glitch: busy pulses, no valid, data unchanged.
    busy_seen = 1'b0;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    check("glitch_busy", busy_seen, 1);
    check("glitch_data", bus.data, last_data);
    drain("glitch");

`ifdef UART_RX_MAJORITY_EN
    // A 1-cycle glitch at mid data bit 3 is outvoted.
    begin
      logic [10:0] bits;
      bits = {1'b1, ^8'hC3, 8'hC3, 1'b0};
      for (int i = 0; i < 11; i++) begin
        bus.rx = bits[i];
        for (int c = 0; c < DIV; c++) begin
          bus.rx = (i == 4 && c == 9) ? ~bits[i] : bits[i];
          @(negedge clk);
        end
      end
      exp_q.push_back('{8'hC3, 1'b0, 1'b0, cyc - DIV});
      last_data = 8'hC3;
      idle_bits(2);
      drain("maj_glitch");
    end
`endif

    // Back-to-back frames with no idle gap.
    send_good(8'h00);
    send_good(8'hFF);
    idle_bits(2);
    drain("b2b");

    // Reset during data bit 4: partial frame is lost, next frame is clean.
    send_frame(8'h55, ^8'h55, 1'b1, 5);
    bus.rx = 1'b0;
    repeat (HALF) @(negedge clk);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    #1;
    check("mid_rst_data", bus.data, 8'h00);
    check("mid_rst_valid", bus.valid, 0);
    check("mid_rst_perr", bus.parity_err, 0);
    check("mid_rst_ferr", bus.frame_err, 0);
    check("mid_rst_busy", bus.busy, 0);
    repeat (3 * DIV) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    drain("aborted");
    send_good(8'h55);
    idle_bits(2);
    drain("post_rst");

    // Randomized frames: random bytes, occasional parity/stop errors, random gaps.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic       par, stp;
      int         gap;
      d   = 8'($urandom);
      par = ($urandom_range(0, 9) == 0) ? ~(^d) : (^d);
      stp = ($urandom_range(0, 9) != 0);
      send_frame(d, par, stp);
      gap = $urandom_range(0, 2 * DIV);
      if (!stp && gap == 0) gap = 1;
      bus.rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    idle_bits(2);
    drain("rand");

    check("valid_one_cycle", wide_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the counterpart of the team's uarttx transmitter. Frame format: 1 start bit, 8 data bits LSB-first, even parity, 1 stop bit.
- Recovers bytes from the asynchronous serial line and presents each byte as a 1-cycle valid pulse with parity and framing status.
- Sits between the board RX pin and the byte consumer (command parser / loopback logic).

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- Derived localparams:
  - DIVIDER = CLK_FREQ/BAUD (integer), clocks per bit.
  - HALF = DIVIDER/2.
  - CNT_WIDTH = $clog2(DIVIDER).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  received byte; held stable until the next valid.
- valid  output  1  1-cycle pulse: data, parity_err and frame_err are updated.
- parity_err  output  1  even-parity mismatch on the last frame; held until the next valid.
- frame_err  output  1  stop bit sampled 0 on the last frame; held until the next valid.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM goes to IDLE.
  - data=8'h00, valid=0, parity_err=0, frame_err=0, busy=0.
  - Synchronizer flops preset to 1 (idle line), so no false start on release.
- Input conditioning:
  - rx passes through a 2-FF synchronizer, giving rx_s.
  - All decisions use rx_s only.
- Bit timer: cnt (CNT_WIDTH bits) counts 0..DIVIDER-1 and wraps; it is the only timing source.
- FSM states and transitions:
  - IDLE: wait for an rx_s 1→0 transition. On detection: cnt=0, go to START.
  - START: at cnt==HALF, sample rx_s.
    - Sample 1: glitch; return to IDLE, no valid.
    - Sample 0: cnt=0, bit index=0, go to DATA.
  - DATA: at cnt==DIVIDER-1 (mid-bit), shift the sample into a receive register LSB-first. After the 8th sample go to PARITY.
  - PARITY: sample at mid-bit, go to STOP.
  - STOP: sample at mid-bit, then:
    - data <= received byte.
    - parity_err <= (^byte) ^ parity_sample.
    - frame_err <= ~stop_sample.
    - valid=1 for exactly one cycle.
    - Go to IDLE immediately (mid-stop), so back-to-back frames are accepted.
- Latency: valid rises on the clock after the stop-bit sample point.
- A frame with errors still produces valid with data updated; the consumer decides whether to drop it.
- Break / line-low after a frame error: IDLE re-arms only after rx_s has been seen 1 for at least one cycle. A continuously low line produces exactly one frame_err and no further valids.
- busy is combinational: state != IDLE.
- Reset mid-frame: the partial frame is discarded, no valid. Reception resumes at the first falling edge after release.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit, including start, is decided by a 2-of-3 majority of rx_s sampled at mid-1, mid and mid+1 cycles. The decision and all downstream timing occur at mid+1, so valid is 1 cycle later than without the macro.
- Not defined: single sample at mid only.
- Start-glitch rule is unchanged apart from using the voted value.

Test Plan:
- All tests use CLK_FREQ=1_600_000, BAUD=100_000: DIVIDER=16, HALF=8.
- Send 0xA5 with parity 0, stop 1 → one valid pulse, data=0xA5, parity_err=0, frame_err=0. busy high from the start edge until the stop mid-point.
- Send 0x01 with parity 0 (correct parity is 1) → valid, data=0x01, parity_err=1, frame_err=0.
- Send 0x3C with correct parity and stop=0, then hold rx low for 40 bit-times, then high → exactly one valid with frame_err=1, then no further valid until a new start after rx returns high.
- Drive rx low for 3 cycles, then high → busy pulses, valid never asserts, data unchanged. With UART_RX_MAJORITY_EN, a 1-cycle glitch at mid-data is rejected and the correct byte is received.
- Send back-to-back 0x00 then 0xFF with no idle gap → two valids, data=0x00 then 0xFF, no errors.
- Assert reset_n=0 during bit 4 of 0x55, release, then send 0x55 → outputs zero during reset, no valid for the aborted frame, then one valid with data=0x55.
